// File: rtl/arith_enc_ctrl_pkg.sv
// Shared types for the arithmetic-encoder feed controller: FSM states, buffered tuple, pipeline tag.
package arith_enc_ctrl_pkg;

  localparam int TUPLE_RANGE_W = 16;
  localparam int TUPLE_SYM_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [TUPLE_RANGE_W-1:0] fl;
    logic [TUPLE_RANGE_W-1:0] fh;
    logic [TUPLE_SYM_W-1:0]   symbol;
    logic [TUPLE_SYM_W:0]     nsyms;
    logic                     last;
  } sym_tuple_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/arith_enc_sym_fifo.sv
// Synchronous FIFO for symbol tuples; a push is readable from the next cycle, never the same one.
// wr_rdy drops when full; rd_vld drops when empty.
module arith_enc_sym_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             general_clk,
  input  logic             reset,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign wr_rdy = (count != FULL_COUNT);
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;

  always_ff @(posedge general_clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arith_encoder_feed_ctrl.sv
// Feeds buffered symbol tuples to the pipelined arithmetic encoder, tags them, and frames each stream.
// Results appear PIPE_LATENCY advances after a pop; out_ready=0 on a valid result freezes encoder and tags.
module arith_encoder_feed_ctrl
  import arith_enc_ctrl_pkg::*;
#(
  parameter int RANGE_WIDTH  = TUPLE_RANGE_W,
  parameter int LOW_WIDTH    = 24,
  parameter int SYMBOL_WIDTH = TUPLE_SYM_W,
  parameter int PIPE_LATENCY = 3,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    general_clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RANGE_WIDTH-1:0]  in_fl,
  input  logic [RANGE_WIDTH-1:0]  in_fh,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic [SYMBOL_WIDTH:0]   in_nsyms,
  input  logic                    in_last,
  output logic                    enc_reset,
  output logic                    enc_advance,
  output logic [RANGE_WIDTH-1:0]  enc_fl,
  output logic [RANGE_WIDTH-1:0]  enc_fh,
  output logic [SYMBOL_WIDTH-1:0] enc_symbol,
  output logic [SYMBOL_WIDTH:0]   enc_nsyms,
  input  logic [RANGE_WIDTH-1:0]  enc_range,
  input  logic [LOW_WIDTH-1:0]    enc_low,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RANGE_WIDTH-1:0]  out_range,
  output logic [LOW_WIDTH-1:0]    out_low,
  output logic                    out_last,
  output logic                    busy
);

  state_t     state;
  sym_tuple_t wr_tuple;
  sym_tuple_t head;
  tag_t       tags [PIPE_LATENCY];
  tag_t       tag_in;
  logic       fifo_vld;
  logic       pop;
  logic       upper_busy;
  logic       flush_done;

  assign wr_tuple = '{fl: in_fl, fh: in_fh, symbol: in_symbol, nsyms: in_nsyms, last: in_last};

  arith_enc_sym_fifo #(
    .WIDTH($bits(sym_tuple_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .general_clk(general_clk),
    .reset      (reset),
    .wr_vld     (in_valid),
    .wr_rdy     (in_ready),
    .wr_dat     (wr_tuple),
    .rd_vld     (fifo_vld),
    .rd_rdy     (pop),
    .rd_dat     (head)
  );

  assign out_valid = tags[PIPE_LATENCY-1].valid;
  assign out_last  = tags[PIPE_LATENCY-1].last;
  assign out_range = enc_range;
  assign out_low   = enc_low;
  assign busy      = (state != IDLE);

  // The encoder and tags only move when the tail result is free to leave.
  assign enc_advance = (!out_valid || out_ready) &&
                       (((state == RUN) && fifo_vld) || (state == FLUSH));
  assign pop         = enc_advance && (state == RUN);
  assign tag_in      = pop ? '{valid: 1'b1, last: head.last} : '0;

  always_comb begin
    enc_fl     = '0;
    enc_fh     = '0;
    enc_symbol = '0;
    enc_nsyms  = '0;
    if (state == RUN) begin
      enc_fl     = head.fl;
      enc_fh     = head.fh;
      enc_symbol = head.symbol;
      enc_nsyms  = head.nsyms;
    end
  end

  // Flush ends on the advance that leaves every tag empty, i.e. the final result just left.
  always_comb begin
    upper_busy = 1'b0;
    for (int i = 0; i < PIPE_LATENCY - 1; i++) upper_busy = upper_busy | tags[i].valid;
    flush_done = enc_advance && !upper_busy;
  end

  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LATENCY; i++) tags[i] <= '0;
    end else if (enc_advance) begin
      tags[0] <= tag_in;
      for (int i = 1; i < PIPE_LATENCY; i++) tags[i] <= tags[i-1];
    end else if (out_valid && out_ready) begin
      tags[PIPE_LATENCY-1] <= '0;
    end
  end

  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      enc_reset <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_vld) begin
            state     <= RUN;
            enc_reset <= 1'b0;
          end else begin
            enc_reset <= 1'b1;
          end
        end
        RUN: begin
          if (pop && head.last) state <= FLUSH;
        end
        FLUSH: begin
          if (flush_done) begin
            state     <= IDLE;
            enc_reset <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          enc_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_encoder_feed_ctrl.sv
// Bench for arith_encoder_feed_ctrl with a stand-in pipelined encoder and a per-frame reference fold.
module tb_arith_encoder_feed_ctrl;

  localparam int PL = 3;
  localparam logic [15:0] INIT_RANGE = 16'h8000;

  typedef struct packed {
    logic [15:0] fl;
    logic [15:0] fh;
    logic [3:0]  sym;
    logic [4:0]  ns;
  } tup_t;

  logic        general_clk, reset;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_fl, in_fh;
  logic [3:0]  in_symbol;
  logic [4:0]  in_nsyms;
  logic        enc_reset, enc_advance;
  logic [15:0] enc_fl, enc_fh, enc_range;
  logic [3:0]  enc_symbol;
  logic [4:0]  enc_nsyms;
  logic [23:0] enc_low;
  logic        out_valid, out_ready, out_last, busy;
  logic [15:0] out_range;
  logic [23:0] out_low;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [40:0] exp_q[$];
  logic [40:0] got_q[$];
  int          got_cyc[$];
  int          in_cyc[$];
  int          rst_cyc[$];
  logic [15:0] m_range;
  logic [23:0] m_low;

  arith_encoder_feed_ctrl dut (
    .general_clk(general_clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_fl(in_fl), .in_fh(in_fh),
    .in_symbol(in_symbol), .in_nsyms(in_nsyms), .in_last(in_last),
    .enc_reset(enc_reset), .enc_advance(enc_advance), .enc_fl(enc_fl), .enc_fh(enc_fh),
    .enc_symbol(enc_symbol), .enc_nsyms(enc_nsyms), .enc_range(enc_range), .enc_low(enc_low),
    .out_valid(out_valid), .out_ready(out_ready), .out_range(out_range), .out_low(out_low),
    .out_last(out_last), .busy(busy)
  );

  initial general_clk = 1'b0;
  always #5 general_clk = ~general_clk;
  always @(posedge general_clk) cyc <= cyc + 1;

  // Stand-in encoder arithmetic: any order-sensitive fold exposes misordered or duplicated symbols.
  function automatic logic [39:0] enc_step(input logic [15:0] r, input logic [23:0] l, input tup_t t);
    logic [15:0] nr;
    logic [23:0] nl;
    nr = (r ^ t.fh) + t.fl + {7'd0, t.sym, t.ns};
    nl = l * 24'd5 + {8'd0, t.fh} + {20'd0, t.sym};
    return {nr, nl};
  endfunction

  // Pipelined encoder stub: PL captures from input to visible range/low.
  tup_t enc_stage [PL-1];
  always @(posedge general_clk) begin
    if (enc_reset) begin
      for (int i = 0; i < PL - 1; i++) enc_stage[i] <= '0;
      enc_range <= INIT_RANGE;
      enc_low   <= '0;
    end else if (enc_advance) begin
      enc_stage[0] <= '{fl: enc_fl, fh: enc_fh, sym: enc_symbol, ns: enc_nsyms};
      for (int i = 1; i < PL - 1; i++) enc_stage[i] <= enc_stage[i-1];
      {enc_range, enc_low} <= enc_step(enc_range, enc_low, enc_stage[PL-2]);
    end
  end

  // Reference: each accepted tuple folds into its frame's state; frames restart from the initial state.
  always @(negedge general_clk) begin
    if (reset) begin
      m_range = INIT_RANGE;
      m_low   = '0;
    end else begin
      if (in_valid && in_ready) begin
        {m_range, m_low} = enc_step(m_range, m_low,
                                    '{fl: in_fl, fh: in_fh, sym: in_symbol, ns: in_nsyms});
        exp_q.push_back({m_range, m_low, in_last});
        in_cyc.push_back(cyc);
        if (in_last) begin
          m_range = INIT_RANGE;
          m_low   = '0;
        end
      end
      if (out_valid && out_ready) begin
        got_q.push_back({out_range, out_low, out_last});
        got_cyc.push_back(cyc);
      end
      if (enc_reset) rst_cyc.push_back(cyc);
    end
  end

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); got_cyc.delete(); in_cyc.delete(); rst_cyc.delete();
  endtask

  task automatic push_one(input logic [15:0] fl, input logic [15:0] fh, input logic [3:0] sym,
                          input logic [4:0] ns, input logic last);
    int w;
    in_fl = fl; in_fh = fh; in_symbol = sym; in_nsyms = ns; in_last = last; in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge general_clk);
      if (in_ready) break;
      w++;
      if (w > 500) begin
        n_chk++; n_fail++;
        $display("FAIL push_timeout in_ready=%0b, required 1 within 500 cycles", in_ready);
        break;
      end
    end
    @(posedge general_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_frame(input int n, input int gap_after, input int gap_len);
    logic [15:0] fl, fh;
    logic [4:0]  ns;
    logic [3:0]  sym;
    for (int i = 0; i < n; i++) begin
      if (i == gap_after) begin
        repeat (gap_len) @(posedge general_clk);
        #1;
      end
      fl  = 16'($urandom_range(32767, 0));
      fh  = 16'($urandom_range(32'd32768, {16'd0, fl}));
      ns  = 5'($urandom_range(16, 2));
      sym = 4'($urandom_range({27'd0, ns} - 32'd1, 0));
      push_one(fl, fh, sym, ns, i == n - 1);
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    forever begin
      @(negedge general_clk);
      if (!busy && !out_valid && got_q.size() == exp_q.size()) break;
      w++;
      if (w > 1000) begin
        n_chk++; n_fail++;
        $display("FAIL drain_timeout busy=%0b results=%0d, required idle with %0d results",
                 busy, got_q.size(), exp_q.size());
        break;
      end
    end
    @(posedge general_clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fl = '0; in_fh = '0; in_symbol = '0; in_nsyms = '0; in_last = 1'b0;
    repeat (3) @(posedge general_clk);
    @(negedge general_clk);
    n_chk++;
    if ({in_ready, out_valid, out_last, busy, enc_reset, enc_advance} !== 6'b100010) begin
      n_fail++;
      $display("FAIL reset_state got %b required 100010", {in_ready, out_valid, out_last, busy, enc_reset, enc_advance});
    end
    @(posedge general_clk); #1;
    reset = 1'b0;
    @(negedge general_clk);
    n_chk++;
    if ({in_ready, out_valid, busy, enc_reset, enc_advance} !== 5'b10010) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b required 10010", {in_ready, out_valid, busy, enc_reset, enc_advance});
    end
    @(posedge general_clk); #1;
  endtask

  task automatic test_single();
    logic [4:0] want [6];
    clear_sb();
    // {out_valid, out_last, busy, enc_reset, enc_advance} for cycles 1..6 after the handshake.
    want[0] = 5'b00010; want[1] = 5'b00101; want[2] = 5'b00101;
    want[3] = 5'b00101; want[4] = 5'b11101; want[5] = 5'b00010;
    push_one(16'd0, 16'd32768, 4'd1, 5'd2, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge general_clk);
      n_chk++;
      if ({out_valid, out_last, busy, enc_reset, enc_advance} !== want[k]) begin
        n_fail++;
        $display("FAIL single_cycle%0d got %b required %b", k + 1,
                 {out_valid, out_last, busy, enc_reset, enc_advance}, want[k]);
      end
    end
    @(posedge general_clk); #1;
    wait_drain();
    n_chk++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL single_result got %h (n=%0d) required %h", got_q.size() ? got_q[0] : 41'h0,
               got_q.size(), exp_q.size() ? exp_q[0] : 41'h0);
    end
  endtask

  task automatic test_stream();
    clear_sb();
    push_frame(10, -1, 0);
    wait_drain();
    n_chk++;
    if (got_q.size() != 10) begin
      n_fail++;
      $display("FAIL stream_count got %0d required 10", got_q.size());
    end
    for (int i = 0; i < 10 && i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stream_result[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
      n_chk++;
      if (got_cyc[i] !== in_cyc[0] + 5 + i) begin
        n_fail++;
        $display("FAIL stream_timing[%0d] got cycle %0d required %0d", i, got_cyc[i], in_cyc[0] + 5 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] held;
    clear_sb();
    fork
      push_frame(10, -1, 0);
      begin
        repeat (6) @(posedge general_clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge general_clk);
          if (k == 0) held = {out_range, out_low};
          n_chk++;
          if (enc_advance !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall%0d enc_advance=%0b out_valid=%0b required 0/1", k, enc_advance, out_valid);
          end
          if (k > 0) begin
            n_chk++;
            if ({out_range, out_low} !== held) begin
              n_fail++;
              $display("FAIL bp_hold%0d got %h required %h", k, {out_range, out_low}, held);
            end
          end
        end
        @(posedge general_clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    n_chk++;
    if (got_q.size() != 10) begin
      n_fail++;
      $display("FAIL bp_count got %0d required 10", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_result[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gap();
    clear_sb();
    push_frame(10, 5, 3);
    wait_drain();
    n_chk++;
    if (got_q.size() != 10) begin
      n_fail++;
      $display("FAIL gap_count got %0d required 10", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gap_result[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit pulse_between;
    clear_sb();
    push_frame(4, -1, 0);
    push_frame(3, -1, 0);
    wait_drain();
    n_chk++;
    if (got_q.size() != 7) begin
      n_fail++;
      $display("FAIL b2b_count got %0d required 7", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_result[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    pulse_between = 1'b0;
    if (got_cyc.size() >= 5)
      foreach (rst_cyc[j]) if (rst_cyc[j] > got_cyc[3] && rst_cyc[j] < got_cyc[4]) pulse_between = 1'b1;
    n_chk++;
    if (!pulse_between) begin
      n_fail++;
      $display("FAIL b2b_enc_reset_pulse seen=0 required 1 between frames");
    end
  endtask

  task automatic test_full_reset();
    int w;
    clear_sb();
    out_ready = 1'b0;
    push_one(16'd100, 16'd20000, 4'd2, 5'd4, 1'b1);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge general_clk);
      w++;
    end
    @(posedge general_clk); #1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        n_chk++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_before_8th in_ready=%0b required 1", in_ready);
        end
      end
      push_one(16'(i * 1000), 16'(i * 1000 + 500), 4'(i), 5'd9, 1'b0);
    end
    @(negedge general_clk);
    n_chk++;
    if ({in_ready, busy, out_valid} !== 3'b011) begin
      n_fail++;
      $display("FAIL full_after_8th {in_ready,busy,out_valid}=%b required 011", {in_ready, busy, out_valid});
    end
    @(posedge general_clk); #1;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({out_valid, busy, in_ready, enc_reset} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_midflush {out_valid,busy,in_ready,enc_reset}=%b required 0011",
               {out_valid, busy, in_ready, enc_reset});
    end
    clear_sb();
    repeat (2) @(posedge general_clk);
    #1 reset = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge general_clk);
    n_chk++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard results=%0d busy=%0b required 0/0", got_q.size(), busy);
    end
    @(posedge general_clk); #1;
    push_frame(3, -1, 0);
    wait_drain();
    n_chk++;
    if (got_q.size() != 3) begin
      n_fail++;
      $display("FAIL post_reset_count got %0d required 3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL post_reset_result[%0d] got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_gap();
    test_back_to_back();
    test_full_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded 50000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
